// File: rtl/tri_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tri_pkg
// Description : TRI request-type encodings shared by TRI sources and arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package tri_pkg;

    typedef enum logic [4:0] {
        TRI_LOAD_RQ  = 5'b00000,
        TRI_STORE_RQ = 5'b00001
    } l15_reqtypes_t;

endpackage
`default_nettype wire

// File: rtl/mshr_tri_entry_if.sv
`default_nettype none
// ============================================================================
// Module      : mshr_tri_entry_if
// Description : Engine-side request/completion bundle plus the TRI slave-port
//               signals of one MSHR entry. The entry owns the TRI request, so
//               it takes the master view; the engine/arbiter side is slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface mshr_tri_entry_if #(
    parameter int CNT_W = 16
);
    // engine request
    logic                   in_valid;
    logic                   in_ready;
    logic                   in_is_store;
    logic [39:0]            in_addr;
    logic [2:0]             in_size;
    logic [127:0]           in_data;
    // engine completion
    logic                   out_valid;
    logic                   out_ready;
    logic [127:0]           out_data;
    logic                   out_err;
    logic                   out_stale;
    logic [CNT_W-1:0]       out_latency;
    // TRI request
    logic                   tri_req_valid;
    tri_pkg::l15_reqtypes_t tri_req_type;
    logic [39:0]            tri_req_addr;
    logic [2:0]             tri_req_size;
    logic [127:0]           tri_req_data;
    logic                   tri_req_ack;
    // TRI response and snoop
    logic                   tri_resp_val;
    logic [127:0]           tri_resp_data;
    logic                   tri_resp_inv_valid;
    logic [39:0]            tri_resp_inv_addr;

    // The MSHR entry itself
    modport master (
        input  in_valid, in_is_store, in_addr, in_size, in_data, out_ready,
        input  tri_req_ack, tri_resp_val, tri_resp_data,
        input  tri_resp_inv_valid, tri_resp_inv_addr,
        output in_ready, out_valid, out_data, out_err, out_stale, out_latency,
        output tri_req_valid, tri_req_type, tri_req_addr, tri_req_size, tri_req_data
    );

    // The cohort engine plus TRI arbiter surrounding the entry
    modport slave (
        output in_valid, in_is_store, in_addr, in_size, in_data, out_ready,
        output tri_req_ack, tri_resp_val, tri_resp_data,
        output tri_resp_inv_valid, tri_resp_inv_addr,
        input  in_ready, out_valid, out_data, out_err, out_stale, out_latency,
        input  tri_req_valid, tri_req_type, tri_req_addr, tri_req_size, tri_req_data
    );

endinterface
`default_nettype wire

// File: rtl/mshr_tri_entry.sv
`default_nettype none
// ============================================================================
// Module      : mshr_tri_entry
// Description : Single outstanding-miss tracker. Accepts one load/store,
//               checks size/alignment, issues it on the TRI port, waits for
//               the filtered response (with optional timeout), tracks line
//               invalidations for loads, and holds the completion until taken.
// Revision    : 1.0 - initial release
// ============================================================================
module mshr_tri_entry #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    mshr_tri_entry_if.master  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [CNT_W-1:0] c_to_last =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam bit               c_to_en   = (TIMEOUT_CYCLES != 0);

    state_t             state_q,     state_d;
    logic               is_store_q,  is_store_d;
    logic [39:0]        addr_q,      addr_d;
    logic [2:0]         size_q,      size_d;
    logic [127:0]       data_q,      data_d;
    logic               in_ready_q,  in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               req_valid_q, req_valid_d;
    logic [127:0]       out_data_q,  out_data_d;
    logic               out_err_q,   out_err_d;
    logic               out_stale_q, out_stale_d;
    logic [CNT_W-1:0]   out_lat_q,   out_lat_d;
    logic [CNT_W-1:0]   lat_cnt_q,   lat_cnt_d;
    logic [CNT_W-1:0]   to_cnt_q,    to_cnt_d;

    logic [3:0]         w_align_mask;
    logic               w_size_ok;
    logic               w_legal;
    logic               w_inv_hit;
    logic               w_timeout;
    logic [CNT_W-1:0]   w_lat_inc;
    logic [CNT_W-1:0]   w_to_inc;
    logic               w_unused_ok;

    // Low address bits that must be zero for the requested access size
    always_comb begin
        w_size_ok    = 1'b1;
        w_align_mask = 4'h0;
        case (bus.in_size)
            3'd1:    w_align_mask = 4'h0;
            3'd2:    w_align_mask = 4'h1;
            3'd3:    w_align_mask = 4'h3;
            3'd4:    w_align_mask = 4'h7;
            3'd5:    w_align_mask = 4'hF;
            default: w_size_ok    = 1'b0;
        endcase
    end

    assign w_legal   = w_size_ok && ((bus.in_addr[3:0] & w_align_mask) == 4'h0);
    // Snoops compare at 16-byte line granularity; only loads can go stale
    assign w_inv_hit = bus.tri_resp_inv_valid && !is_store_q &&
                       (bus.tri_resp_inv_addr[39:4] == addr_q[39:4]);
    assign w_timeout = c_to_en && (to_cnt_q == c_to_last);
    assign w_lat_inc = (lat_cnt_q == c_cnt_max) ? lat_cnt_q : lat_cnt_q + 1'b1;
    assign w_to_inc  = (to_cnt_q  == c_cnt_max) ? to_cnt_q  : to_cnt_q  + 1'b1;

    // Next-state, latching and completion-capture logic
    always_comb begin
        state_d     = state_q;
        is_store_d  = is_store_q;
        addr_d      = addr_q;
        size_d      = size_q;
        data_d      = data_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        req_valid_d = req_valid_q;
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;
        out_stale_d = out_stale_q;
        out_lat_d   = out_lat_q;
        lat_cnt_d   = lat_cnt_q;
        to_cnt_d    = to_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    is_store_d  = bus.in_is_store;
                    addr_d      = bus.in_addr;
                    size_d      = bus.in_size;
                    data_d      = bus.in_is_store ? bus.in_data : '0;
                    in_ready_d  = 1'b0;
                    out_data_d  = '0;
                    out_err_d   = 1'b0;
                    out_stale_d = 1'b0;
                    out_lat_d   = '0;
                    lat_cnt_d   = '0;
                    to_cnt_d    = '0;
                    if (w_legal) begin
                        state_d     = S_REQ;
                        req_valid_d = 1'b1;
                    end else begin
                        // Illegal requests complete immediately without touching TRI
                        state_d     = S_DONE;
                        out_valid_d = 1'b1;
                        out_err_d   = 1'b1;
                    end
                end
            end
            S_REQ: begin
                lat_cnt_d = w_lat_inc;
                if (w_inv_hit) begin
                    out_stale_d = 1'b1;
                end
                if (bus.tri_req_ack) begin
                    state_d     = S_WAIT;
                    req_valid_d = 1'b0;
                    to_cnt_d    = '0;
                end
            end
            S_WAIT: begin
                lat_cnt_d = w_lat_inc;
                to_cnt_d  = w_to_inc;
                if (w_inv_hit) begin
                    out_stale_d = 1'b1;
                end
                // A response in the timeout cycle takes priority over the timeout
                if (bus.tri_resp_val) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    out_data_d  = is_store_q ? '0 : bus.tri_resp_data;
                    out_err_d   = 1'b0;
                    out_lat_d   = w_lat_inc;
                end else if (w_timeout) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    out_data_d  = '0;
                    out_err_d   = 1'b1;
                    out_lat_d   = w_lat_inc;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = S_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                req_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            is_store_q  <= 1'b0;
            addr_q      <= '0;
            size_q      <= '0;
            data_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            req_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
            out_stale_q <= 1'b0;
            out_lat_q   <= '0;
            lat_cnt_q   <= '0;
            to_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            is_store_q  <= is_store_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            data_q      <= data_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            req_valid_q <= req_valid_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
            out_stale_q <= out_stale_d;
            out_lat_q   <= out_lat_d;
            lat_cnt_q   <= lat_cnt_d;
            to_cnt_q    <= to_cnt_d;
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_data      = out_data_q;
    assign bus.out_err       = out_err_q;
    assign bus.out_stale     = out_stale_q;
    assign bus.out_latency   = out_lat_q;
    assign bus.tri_req_valid = req_valid_q;
    assign bus.tri_req_type  = is_store_q ? tri_pkg::TRI_STORE_RQ : tri_pkg::TRI_LOAD_RQ;
    assign bus.tri_req_addr  = addr_q;
    assign bus.tri_req_size  = size_q;
    assign bus.tri_req_data  = data_q;

    // Byte-within-line bits of the snoop address are irrelevant
    assign w_unused_ok = ^bus.tri_resp_inv_addr[3:0];

endmodule
`default_nettype wire
